usb_out_txn_ctrl: RTL and testbench
===================================

// Module: usb_out_txn_ctrl
// PURPOSE
//  Sequences one USB host OUT transaction through the existing bitStreamEncoder -> bitStuffer -> nrzi
//  transmit path: OUT token, inter-packet gap, DATA0 packet, then waits for the device handshake.
//  Retries on NAK, timeout or bad response up to MAX_RETRIES, then reports a final status.
//  Sits between the host request interface and the encoder; consumes decoded PIDs from the rx side.
// PARAMETERS
//  MAX_RETRIES   3    extra attempts after the first (total attempts = MAX_RETRIES+1), >=0
//  IPG_CYCLES    4    idle cycles between end of one tx packet and next pkt_avail, >=1
//  TIMEOUT_CYC   64   cycles to wait in handshake phase before declaring timeout, >=2
// PORTS
//  clk          in   1   clock
//  rst          in   1   reset, asynchronous, active-high
//  req          in   1   start transaction; sampled only in IDLE
//  req_addr     in   7   device address
//  req_endp     in   4   endpoint number
//  req_data     in   64  OUT payload
//  busy         out  1   high from cycle after req acceptance until done
//  done         out  1   one-cycle pulse: transaction finished
//  status       out  2   valid with done: 00 ACK, 01 NAK limit, 10 timeout limit, 11 bad response limit
//  retries_used out  $clog2(MAX_RETRIES+1)  retries consumed, valid with done
//  pkt_avail    out  1   one-cycle pulse to encoder: capture pid_in/addr_in/endp_in/data_in
//  pid_in       out  8   PID byte to encoder ({~pid,pid})
//  addr_in      out  7   to encoder
//  endp_in      out  4   to encoder
//  data_in      out  64  to encoder
//  enc_last     in   1   encoder last-bit flag
//  stall        in   1   bit-stuffer stall; packet end = enc_last & ~stall at a clk edge
//  rx_valid     in   1   one-cycle pulse: received packet decoded
//  rx_pid       in   8   received PID byte
//  rx_err       in   1   received packet had CRC/PID-check error (valid with rx_valid)
// BEHAVIOUR
//  - All outputs registered. Reset: state IDLE, busy=0, done=0, status=00, retries_used=0,
//    pkt_avail=0, pid_in=0, addr_in=0, endp_in=0, data_in=0, timers/counters 0.
//  - PIDs: OUT 8'b1110_0001, DATA0 8'b1100_0011, ACK 8'b1101_0010, NAK 8'b0101_1010.
//  - IDLE: req=1 latches addr/endp/data -> SEND_TOK; busy=1 next cycle. req ignored while busy.
//  - SEND_TOK: pkt_avail=1 for exactly one cycle, pid_in=OUT, addr_in/endp_in latched -> WAIT_TOK.
//  - WAIT_TOK: hold pid_in/addr_in/endp_in stable; on enc_last&~stall -> GAP_D. stall freezes progress.
//  - GAP_D: count IPG_CYCLES cycles -> SEND_DAT.
//  - SEND_DAT: pkt_avail one cycle, pid_in=DATA0, data_in=latched payload -> WAIT_DAT.
//  - WAIT_DAT: on enc_last&~stall -> WAIT_HS, timer cleared.
//  - WAIT_HS: timer increments each cycle. Outcomes:
//      rx_valid & ~rx_err & rx_pid==ACK -> DONE, status 00.
//      rx_valid & ~rx_err & rx_pid==NAK -> fail cause NAK.
//      rx_valid & (rx_err | other PID)  -> fail cause BAD.
//      timer==TIMEOUT_CYC-1, no rx_valid -> fail cause TIMEOUT.
//    rx_valid in same cycle as timeout: rx_valid wins. rx_valid outside WAIT_HS ignored.
//  - Fail: if retries_used<MAX_RETRIES: retries_used++, -> GAP_R (IPG_CYCLES) -> SEND_TOK (full
//    token+data resend, DATA0 again). Else -> DONE, status = cause (01/10/11).
//  - DONE: done=1 one cycle, status/retries_used held until next req accepted; busy=0 -> IDLE.
//  - Reset mid-transaction: immediate return to IDLE, pkt_avail forced 0, no done pulse.
//  - Counters sized to hold max(IPG_CYCLES,TIMEOUT_CYC); no wrap in legal operation.
// TESTING
//  1. req addr=5 endp=4 data=CAFEBABEDEADBEEF, ACK 10 cyc after data end -> 2 pkt_avail pulses
//     (OUT then DATA0), done with status 00, retries_used 0.
//  2. MAX_RETRIES=3, respond NAK, NAK, ACK -> 6 pkt_avail pulses, status 00, retries_used 2.
//  3. No response, TIMEOUT_CYC=64 -> 4 attempts, each WAIT_HS exactly 64 cyc, status 10, retries 3.
//  4. stall=1 for 5 cycles while enc_last=1 in WAIT_TOK -> no DATA0 pkt_avail until stall drops,
//     then exactly IPG_CYCLES idle cycles before it.
//  5. rx_valid with rx_err=1 (pid ACK) on all attempts -> status 11; rx_valid with ACK on final
//     timeout cycle -> status 00.
//  6. rst asserted in WAIT_HS -> busy=0, pkt_avail=0, no done; new req runs clean to status 00.

Source files
------------

// File: rtl/usb_out_txn_ctrl.sv
// Host OUT transaction sequencer: OUT token, inter-packet gap, DATA0, then handshake wait.
// NAK, timeout or a corrupt reply trigger a full resend until the retry budget runs out.
module usb_out_txn_ctrl #(
  parameter int MAX_RETRIES = 3,
  parameter int IPG_CYCLES  = 4,
  parameter int TIMEOUT_CYC = 64,
  localparam int RETRY_W    = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req,
  input  logic [6:0]         req_addr,
  input  logic [3:0]         req_endp,
  input  logic [63:0]        req_data,
  output logic               busy,
  output logic               done,
  output logic [1:0]         status,
  output logic [RETRY_W-1:0] retries_used,
  output logic               pkt_avail,
  output logic [7:0]         pid_in,
  output logic [6:0]         addr_in,
  output logic [3:0]         endp_in,
  output logic [63:0]        data_in,
  input  logic               enc_last,
  input  logic               stall,
  input  logic               rx_valid,
  input  logic [7:0]         rx_pid,
  input  logic               rx_err
);

  localparam logic [7:0] PID_OUT   = 8'b1110_0001;
  localparam logic [7:0] PID_DATA0 = 8'b1100_0011;
  localparam logic [7:0] PID_ACK   = 8'b1101_0010;
  localparam logic [7:0] PID_NAK   = 8'b0101_1010;

  localparam logic [1:0] ST_ACK     = 2'b00;
  localparam logic [1:0] ST_NAK     = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_BAD     = 2'b11;

  localparam int CNT_MAX = (IPG_CYCLES > TIMEOUT_CYC) ? IPG_CYCLES : TIMEOUT_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [3:0] {
    IDLE,
    SEND_TOK,
    WAIT_TOK,
    GAP_D,
    SEND_DAT,
    WAIT_DAT,
    WAIT_HS,
    GAP_R,
    DONE
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [6:0]        addr_q;
  logic [3:0]        endp_q;
  logic [63:0]       data_q;

  logic              pkt_end;
  logic              rx_ack;
  logic              hs_fail;
  logic [1:0]        hs_cause;

  assign pkt_end = enc_last & ~stall;
  assign rx_ack  = rx_valid & ~rx_err & (rx_pid == PID_ACK);

  // A reply in the last timeout cycle takes precedence over the timeout itself.
  always_comb begin
    hs_fail  = 1'b0;
    hs_cause = ST_ACK;
    if (rx_valid) begin
      if (!rx_ack) begin
        hs_fail  = 1'b1;
        hs_cause = (!rx_err && rx_pid == PID_NAK) ? ST_NAK : ST_BAD;
      end
    end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
      hs_fail  = 1'b1;
      hs_cause = ST_TIMEOUT;
    end
  end

  // pkt_avail is raised on entry to SEND_TOK/SEND_DAT so the gap before it is exactly IPG_CYCLES.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      addr_q       <= '0;
      endp_q       <= '0;
      data_q       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      status       <= ST_ACK;
      retries_used <= '0;
      pkt_avail    <= 1'b0;
      pid_in       <= '0;
      addr_in      <= '0;
      endp_in      <= '0;
      data_in      <= '0;
    end else begin
      pkt_avail <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            addr_q       <= req_addr;
            endp_q       <= req_endp;
            data_q       <= req_data;
            addr_in      <= req_addr;
            endp_in      <= req_endp;
            pid_in       <= PID_OUT;
            pkt_avail    <= 1'b1;
            busy         <= 1'b1;
            status       <= ST_ACK;
            retries_used <= '0;
            state        <= SEND_TOK;
          end
        end
        SEND_TOK: state <= WAIT_TOK;
        WAIT_TOK: begin
          if (pkt_end) begin
            cnt   <= '0;
            state <= GAP_D;
          end
        end
        GAP_D: begin
          if (cnt == CNT_W'(IPG_CYCLES - 1)) begin
            cnt       <= '0;
            pid_in    <= PID_DATA0;
            data_in   <= data_q;
            pkt_avail <= 1'b1;
            state     <= SEND_DAT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        SEND_DAT: state <= WAIT_DAT;
        WAIT_DAT: begin
          if (pkt_end) begin
            cnt   <= '0;
            state <= WAIT_HS;
          end
        end
        WAIT_HS: begin
          if (rx_ack) begin
            status <= ST_ACK;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= DONE;
          end else if (hs_fail) begin
            if (retries_used < RETRY_W'(MAX_RETRIES)) begin
              retries_used <= retries_used + RETRY_W'(1);
              cnt          <= '0;
              state        <= GAP_R;
            end else begin
              status <= hs_cause;
              done   <= 1'b1;
              busy   <= 1'b0;
              state  <= DONE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        GAP_R: begin
          if (cnt == CNT_W'(IPG_CYCLES - 1)) begin
            cnt       <= '0;
            pid_in    <= PID_OUT;
            addr_in   <= addr_q;
            endp_in   <= endp_q;
            pkt_avail <= 1'b1;
            state     <= SEND_TOK;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_out_txn_ctrl.sv
// Bench for usb_out_txn_ctrl: emulates encoder and device replies, predicts the final
// status, retry count, packet count and phase latencies from per-attempt reply scripts.
module tb_usb_out_txn_ctrl;

  localparam int MAXR = 3;
  localparam int IPG  = 4;
  localparam int TMO  = 64;
  localparam int RW   = $clog2(MAXR + 1);
  localparam int LIMIT = TMO + IPG + 40;

  localparam logic [7:0] PID_OUT   = 8'hE1;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;

  typedef enum int {R_ACK, R_NAK, R_ERR, R_BADPID, R_NONE} resp_t;

  logic          clk;
  logic          rst;
  logic          req;
  logic [6:0]    req_addr;
  logic [3:0]    req_endp;
  logic [63:0]   req_data;
  logic          busy;
  logic          done;
  logic [1:0]    status;
  logic [RW-1:0] retries_used;
  logic          pkt_avail;
  logic [7:0]    pid_in;
  logic [6:0]    addr_in;
  logic [3:0]    endp_in;
  logic [63:0]   data_in;
  logic          enc_last;
  logic          stall;
  logic          rx_valid;
  logic [7:0]    rx_pid;
  logic          rx_err;

  int checks = 0;
  int errors = 0;
  int pkt_count = 0;
  int done_count = 0;

  resp_t resp_kind [0:MAXR];
  int    resp_delay [0:MAXR];

  logic [6:0]  cur_addr;
  logic [3:0]  cur_endp;
  logic [63:0] cur_data;

  usb_out_txn_ctrl #(
    .MAX_RETRIES(MAXR),
    .IPG_CYCLES (IPG),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_addr    (req_addr),
    .req_endp    (req_endp),
    .req_data    (req_data),
    .busy        (busy),
    .done        (done),
    .status      (status),
    .retries_used(retries_used),
    .pkt_avail   (pkt_avail),
    .pid_in      (pid_in),
    .addr_in     (addr_in),
    .endp_in     (endp_in),
    .data_in     (data_in),
    .enc_last    (enc_last),
    .stall       (stall),
    .rx_valid    (rx_valid),
    .rx_pid      (rx_pid),
    .rx_err      (rx_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pkt_avail) pkt_count <= pkt_count + 1;
    if (done) done_count <= done_count + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: walk the reply script attempt by attempt.
  function automatic void model(output int st, output int rt, output int att);
    int cause;
    st = 0; rt = 0; att = 0;
    for (int a = 0; a <= MAXR; a++) begin
      att = a + 1;
      rt  = a;
      if (resp_kind[a] == R_ACK) begin
        st = 0;
        return;
      end
      case (resp_kind[a])
        R_NAK:   cause = 1;
        R_NONE:  cause = 2;
        default: cause = 3;
      endcase
      if (a == MAXR) begin
        st = cause;
        return;
      end
    end
  endfunction

  task automatic set_resp(input int a, input resp_t k, input int d);
    resp_kind[a]  = k;
    resp_delay[a] = d;
  endtask

  task automatic drive_resp(input resp_t k);
    logic [7:0] p;
    rx_valid = 1'b1;
    rx_err   = 1'b0;
    case (k)
      R_ACK: rx_pid = PID_ACK;
      R_NAK: rx_pid = PID_NAK;
      R_ERR: begin
        rx_pid = PID_ACK;
        rx_err = 1'b1;
      end
      default: begin
        p = 8'($urandom);
        while (p == PID_ACK || p == PID_NAK) p = 8'($urandom);
        rx_pid = p;
      end
    endcase
  endtask

  task automatic expect_pkt(input string tag, input logic [7:0] pid, input bit is_tok, input int exp_gap);
    int n = 0;
    while (!pkt_avail && n < LIMIT) begin
      tick();
      n++;
    end
    if (exp_gap >= 0) check_output({tag, "_gap"}, 64'(n), 64'(exp_gap));
    check_output({tag, "_pkt"}, 64'(pkt_avail), 64'd1);
    check_output({tag, "_pid"}, 64'(pid_in), 64'(pid));
    check_output({tag, "_busy"}, 64'(busy), 64'd1);
    if (is_tok) begin
      check_output({tag, "_addr"}, 64'(addr_in), 64'(cur_addr));
      check_output({tag, "_endp"}, 64'(endp_in), 64'(cur_endp));
    end else begin
      check_output({tag, "_data"}, data_in, cur_data);
    end
  endtask

  // Encoder emulation; a stray reply and request are injected where both must be ignored.
  task automatic finish_packet(input int enc_len, input int stall_len);
    int pc;
    rx_valid = 1'b1; rx_pid = PID_ACK; rx_err = 1'b0;
    req = 1'b1; req_addr = ~cur_addr; req_endp = ~cur_endp; req_data = ~cur_data;
    tick();
    rx_valid = 1'b0; req = 1'b0;
    repeat (enc_len - 1) tick();
    pc = pkt_count;
    enc_last = 1'b1;
    stall = (stall_len > 0);
    repeat (stall_len) tick();
    if (stall_len > 0) check_output("stall_hold", 64'(pkt_count), 64'(pc));
    stall = 1'b0;
    tick();
    enc_last = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [6:0] a_addr, input logic [3:0] a_endp,
                                input logic [63:0] a_data, input int stall_tok);
    int st, rt, att, p0, d0, n, win, lat;
    bit fin;
    model(st, rt, att);
    p0 = pkt_count;
    d0 = done_count;
    cur_addr = a_addr; cur_endp = a_endp; cur_data = a_data;
    req_addr = a_addr; req_endp = a_endp; req_data = a_data;
    req = 1'b1;
    tick();
    req = 1'b0;
    check_output("busy_after_req", 64'(busy), 64'd1);
    for (int a = 0; a <= MAXR; a++) begin
      expect_pkt("tok", PID_OUT, 1'b1, (a == 0) ? 0 : -1);
      finish_packet(int'($urandom_range(2, 5)), (a == 0) ? stall_tok : 0);
      expect_pkt("dat", PID_DATA0, 1'b0, IPG);
      finish_packet(int'($urandom_range(2, 5)), 0);
      fin = (resp_kind[a] == R_ACK) || (a == MAXR);
      if (resp_kind[a] == R_NONE) begin
        win = TMO;
        lat = 0;
      end else begin
        win = resp_delay[a];
        repeat (win - 1) tick();
        drive_resp(resp_kind[a]);
        tick();
        rx_valid = 1'b0; rx_err = 1'b0;
        lat = win;
      end
      n = 0;
      while (!pkt_avail && !done && n < LIMIT) begin
        tick();
        n++;
      end
      check_output("hs_latency", 64'(lat + n), 64'(win + (fin ? 0 : IPG)));
      check_output("hs_event", 64'(done), 64'(fin));
      if (fin) break;
    end
    check_output_done(st, rt, att, p0, d0);
  endtask

  task automatic check_output_done(input int st, input int rt, input int att, input int p0, input int d0);
    check_output("done_pulse", 64'(done), 64'd1);
    check_output("done_busy", 64'(busy), 64'd0);
    check_output("status", 64'(status), 64'(st));
    check_output("retries_used", 64'(retries_used), 64'(rt));
    check_output("pkt_total", 64'(pkt_count - p0), 64'(2 * att));
    tick();
    check_output("done_one_cycle", 64'(done), 64'd0);
    check_output("status_held", 64'(status), 64'(st));
    check_output("done_total", 64'(done_count - d0), 64'd1);
  endtask

  initial begin
    int d0;
    rst = 1'b1; req = 1'b0; req_addr = '0; req_endp = '0; req_data = '0;
    enc_last = 1'b0; stall = 1'b0; rx_valid = 1'b0; rx_pid = '0; rx_err = 1'b0;
    cur_addr = '0; cur_endp = '0; cur_data = '0;
    repeat (3) tick();
    check_output("rst_busy", 64'(busy), 64'd0);
    check_output("rst_done", 64'(done), 64'd0);
    check_output("rst_status", 64'(status), 64'd0);
    check_output("rst_retries", 64'(retries_used), 64'd0);
    check_output("rst_pkt", 64'(pkt_avail), 64'd0);
    check_output("rst_pid", 64'(pid_in), 64'd0);
    check_output("rst_addr", 64'(addr_in), 64'd0);
    check_output("rst_endp", 64'(endp_in), 64'd0);
    check_output("rst_data", data_in, 64'd0);
    rst = 1'b0;
    tick();

    $display("[TB] basic ACK");
    set_resp(0, R_ACK, 10);
    apply_stimulus(7'd5, 4'd4, 64'hCAFEBABEDEADBEEF, 0);

    $display("[TB] NAK, NAK, ACK");
    set_resp(0, R_NAK, 5); set_resp(1, R_NAK, 7); set_resp(2, R_ACK, 3);
    apply_stimulus(7'h2A, 4'h1, 64'h0123456789ABCDEF, 0);

    $display("[TB] timeout on every attempt");
    for (int i = 0; i <= MAXR; i++) set_resp(i, R_NONE, 0);
    apply_stimulus(7'h11, 4'h7, 64'hFFFF0000FFFF0000, 0);

    $display("[TB] token stall");
    set_resp(0, R_ACK, 4);
    apply_stimulus(7'h33, 4'h2, 64'h5555AAAA5555AAAA, 5);

    $display("[TB] corrupt ACK on every attempt");
    for (int i = 0; i <= MAXR; i++) set_resp(i, R_ERR, int'($urandom_range(1, 20)));
    apply_stimulus(7'h7F, 4'hF, 64'h1, 0);

    $display("[TB] ACK on last timeout cycle");
    set_resp(0, R_ACK, TMO);
    apply_stimulus(7'h01, 4'h0, 64'h8000000000000000, 0);

    $display("[TB] reset during handshake");
    cur_addr = 7'h44; cur_endp = 4'h9; cur_data = 64'hDEADBEEF00C0FFEE;
    req_addr = cur_addr; req_endp = cur_endp; req_data = cur_data;
    req = 1'b1;
    tick();
    req = 1'b0;
    expect_pkt("rtok", PID_OUT, 1'b1, 0);
    finish_packet(3, 0);
    expect_pkt("rdat", PID_DATA0, 1'b0, IPG);
    finish_packet(3, 0);
    repeat (5) tick();
    d0 = done_count;
    rst = 1'b1;
    #1;
    check_output("mid_rst_busy", 64'(busy), 64'd0);
    check_output("mid_rst_pkt", 64'(pkt_avail), 64'd0);
    check_output("mid_rst_done", 64'(done), 64'd0);
    tick();
    rst = 1'b0;
    repeat (TMO + IPG + 10) tick();
    check_output("mid_rst_no_done", 64'(done_count - d0), 64'd0);
    set_resp(0, R_ACK, 6);
    apply_stimulus(7'h45, 4'h3, 64'h0F0F0F0F0F0F0F0F, 0);

    $display("[TB] randomized transactions");
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i <= MAXR; i++) begin
        set_resp(i, resp_t'($urandom_range(0, 4)),
                 ($urandom_range(0, 7) == 0) ? TMO : int'($urandom_range(1, 20)));
      end
      apply_stimulus(7'($urandom), 4'($urandom), {$urandom, $urandom}, int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
